// File: rtl/cuppa_pkg.sv
// Shared defaults, sequencer state encoding and register map for the scratch DPRAM block.
package cuppa_pkg;

    localparam int ADR_W_DEF  = 11;
    localparam int DATA_W_DEF = 16;
    localparam int DIV_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Register decoder addresses of the pattern player fields
    localparam logic [11:0] REG_CFG_START_ADR = 12'h8F0;
    localparam logic [11:0] REG_CFG_LEN       = 12'h8F1;
    localparam logic [11:0] REG_CFG_DIV       = 12'h8F2;
    localparam logic [11:0] REG_CTRL          = 12'h8F3;
    localparam logic [11:0] REG_STATUS        = 12'h8F4;
    localparam logic [11:0] REG_LOOP_CNT      = 12'h8F5;

endpackage

// File: rtl/dpram_pattern_player_if.sv
// Configuration, DPRAM port-B and pattern-stream signals of the pattern player.
interface dpram_pattern_player_if
    import cuppa_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF
);
    logic [ADR_W-1:0]  cfg_start_adr;
    logic [ADR_W:0]    cfg_len;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_loop;
    logic              start;
    logic              stop;
    logic [ADR_W-1:0]  dp_adr;
    logic [DATA_W-1:0] dp_dout;
    logic [DATA_W-1:0] pat_data;
    logic              pat_valid;
    logic              busy;
    logic              done;
    logic [15:0]       loop_cnt;

    modport master (
        input  cfg_start_adr, cfg_len, cfg_div, cfg_loop, start, stop, dp_dout,
        output dp_adr, pat_data, pat_valid, busy, done, loop_cnt
    );

    modport slave (
        output cfg_start_adr, cfg_len, cfg_div, cfg_loop, start, stop, dp_dout,
        input  dp_adr, pat_data, pat_valid, busy, done, loop_cnt
    );
endinterface

// File: rtl/dpram_pattern_player_rate_divider.sv
// Word-period divider: one-cycle tick every div+1 cycles while enabled.
module rate_divider
    import cuppa_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] reload;

    // With div=0 the tick lands on the first cycle after restart
    assign tick = en && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            reload <= '0;
        end else if (restart) begin
            cnt    <= div;
            reload <= div;
        end else if (tick) begin
            cnt <= reload;
        end else if (en) begin
            cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/dpram_pattern_player.sv
// Port-B sequencer: plays a window of DPRAM words as a registered stream, one-shot or looping.
module dpram_pattern_player
    import cuppa_pkg::*;
#(
    parameter int ADR_W  = ADR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DIV_W  = DIV_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    dpram_pattern_player_if.master bus
);
    localparam logic [ADR_W:0] MAX_LEN = {1'b1, {ADR_W{1'b0}}};

    function automatic logic [ADR_W:0] clamp_len(input logic [ADR_W:0] l);
        return (l > MAX_LEN) ? MAX_LEN : l;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t           state, state_nxt;
    logic [ADR_W-1:0] start_adr_q;
    logic [ADR_W:0]   len_q;
    logic             loop_q;
    logic [ADR_W:0]   idx;
    logic             accept, len_zero, at_last, tick, issue;
    logic             vld_p0, vld_p1, vld_p2;
    logic             last_p0, last_p1, last_p2;
    logic             tap_vld, tap_last;

    assign accept   = (state == IDLE) && bus.start && !bus.stop;
    assign len_zero = (bus.cfg_len == '0);
    assign at_last  = (idx == len_q - 1'b1);
    assign issue    = (state == RUN) && tick && !bus.stop && !(at_last && !loop_q);
    assign tap_vld  = (RD_LAT == 1) ? vld_p1 : vld_p2;
    assign tap_last = (RD_LAT == 1) ? last_p1 : last_p2;

    rate_divider #(.DIV_W(DIV_W)) u_div (
        .clk     (clk),
        .rst     (rst),
        .restart (accept),
        .en      (state == RUN),
        .div     (bus.cfg_div),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && !len_zero) state_nxt = RUN;
            RUN:     if (bus.stop) state_nxt = IDLE;
                     else if (at_last && !loop_q) state_nxt = DRAIN;
            DRAIN:   if (bus.stop || bus.done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_adr_q   <= '0;
            len_q         <= '0;
            loop_q        <= 1'b0;
            idx           <= '0;
            bus.dp_adr    <= '0;
            bus.pat_data  <= '0;
            bus.pat_valid <= 1'b0;
            bus.done      <= 1'b0;
            bus.loop_cnt  <= '0;
            vld_p0        <= 1'b0;
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            last_p0       <= 1'b0;
            last_p1       <= 1'b0;
            last_p2       <= 1'b0;
        end else begin
            // p0: issue on dp_adr -> p1/p2: read latency -> pat_data capture
            vld_p0        <= 1'b0;
            vld_p1        <= vld_p0;
            vld_p2        <= vld_p1;
            last_p1       <= last_p0;
            last_p2       <= last_p1;
            bus.pat_valid <= 1'b0;
            bus.done      <= 1'b0;
            if (accept) begin
                start_adr_q  <= bus.cfg_start_adr;
                len_q        <= clamp_len(bus.cfg_len);
                loop_q       <= bus.cfg_loop;
                bus.loop_cnt <= '0;
                if (len_zero) begin
                    bus.done <= 1'b1;
                end else begin
                    bus.dp_adr <= bus.cfg_start_adr;
                    idx        <= '0;
                    vld_p0     <= 1'b1;
                    last_p0    <= (clamp_len(bus.cfg_len) == 1);
                end
            end else if (bus.stop && state != IDLE) begin
                vld_p0 <= 1'b0;
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
            end else begin
                if (issue) begin
                    vld_p0 <= 1'b1;
                    if (at_last) begin
                        bus.dp_adr <= start_adr_q;
                        idx        <= '0;
                        last_p0    <= (len_q == 1);
                    end else begin
                        bus.dp_adr <= bus.dp_adr + 1'b1;
                        idx        <= idx + 1'b1;
                        last_p0    <= (idx + 1'b1 == len_q - 1'b1);
                    end
                end
                if (tap_vld) begin
                    bus.pat_data  <= bus.dp_dout;
                    bus.pat_valid <= 1'b1;
                    if (tap_last) begin
                        bus.loop_cnt <= sat_inc(bus.loop_cnt);
                        bus.done     <= !loop_q;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_dpram_pattern_player.sv
// Randomized self-checking bench for dpram_pattern_player with a cycle-level reference model.
module tb_dpram_pattern_player;
    localparam int ADR_W  = 11;
    localparam int DATA_W = 16;
    localparam int DIV_W  = 16;
    localparam int RD_LAT = 1;
    localparam int NWORDS = 2 ** ADR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;

    logic [DATA_W-1:0] mem [NWORDS];
    logic [DATA_W-1:0] rd1, rd2;
    logic [DATA_W-1:0] exp_data = '0;
    logic [ADR_W-1:0]  g_adr = '0;
    int                g_lc = 0;

    dpram_pattern_player_if #(.ADR_W(ADR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

    dpram_pattern_player #(.ADR_W(ADR_W), .DATA_W(DATA_W), .DIV_W(DIV_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // DPRAM port B stand-in
    always @(posedge clk) begin
        rd1 <= mem[bus.dp_adr];
        rd2 <= rd1;
    end
    assign bus.dp_dout = (RD_LAT == 1) ? rd1 : rd2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_outputs(input bit ev, input bit ed, input bit eb);
        chk("pat_valid", 32'(bus.pat_valid), 32'(ev));
        chk("done", 32'(bus.done), 32'(ed));
        chk("busy", 32'(bus.busy), 32'(eb));
        chk("loop_cnt", 32'(bus.loop_cnt), 32'(g_lc));
        chk("dp_adr", 32'(bus.dp_adr), 32'(g_adr));
        chk("pat_data", 32'(bus.pat_data), 32'(exp_data));
    endtask

    // One playback; cycle 1 is the first cycle after the start edge.
    task automatic run(input int sa, input int len_in, input int div, input bit lp,
                       input int stop_cyc, input int restart_cyc);
        int len, p, last_cyc, ncyc, t, te, k, beats, ceff, nb;
        bit ev, ed, eb, stopped;
        len      = (len_in > NWORDS) ? NWORDS : len_in;
        p        = div + 1;
        last_cyc = 2 + RD_LAT + (len - 1) * p;
        nb       = lp ? 32'h3FFF_FFFF : len;
        if (lp)            ncyc = stop_cyc + 3;
        else if (len == 0) ncyc = 4;
        else               ncyc = last_cyc + 3;
        @(negedge clk);
        bus.cfg_start_adr = ADR_W'(sa);
        bus.cfg_len       = (ADR_W+1)'(len_in);
        bus.cfg_div       = DIV_W'(div);
        bus.cfg_loop      = lp;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        g_lc = 0;
        for (int c = 1; c <= ncyc; c++) begin
            stopped = (stop_cyc > 0) && (c > stop_cyc);
            ceff    = stopped ? stop_cyc : c;
            if (len == 0) begin
                ev = 1'b0;
                ed = (c == 1);
                eb = 1'b0;
            end else begin
                t  = c - (2 + RD_LAT);
                ev = !stopped && t >= 0 && (t % p == 0) && (t / p < nb);
                if (ev) exp_data = mem[ADR_W'(sa + (t / p) % len)];
                te    = ceff - (2 + RD_LAT);
                beats = (te < 0) ? 0 : ((te / p + 1 < nb) ? te / p + 1 : nb);
                g_lc  = (beats / len > 65535) ? 65535 : beats / len;
                ed    = !lp && !stopped && (c == last_cyc);
                eb    = !stopped && (lp || c <= last_cyc);
                k     = (ceff - 1) / p;
                if (!lp && k > len - 1) k = len - 1;
                g_adr = ADR_W'(sa + k % len);
            end
            check_outputs(ev, ed, eb);
            if (c == restart_cyc) begin
                bus.start         = 1'b1;
                bus.cfg_start_adr = ADR_W'($urandom);
                bus.cfg_len       = (ADR_W+1)'($urandom_range(1, 20));
                bus.cfg_div       = DIV_W'($urandom_range(0, 5));
                bus.cfg_loop      = !lp;
            end
            if (c == stop_cyc) bus.stop = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            bus.stop  = 1'b0;
        end
    endtask

    initial begin
        int sa, len, div, stop_cyc, restart_cyc, last_cyc;
        bit lp;
        for (int i = 0; i < NWORDS; i++) mem[i] = DATA_W'($urandom);
        for (int i = 0; i < 4; i++) mem[16 + i] = DATA_W'(16'hA0 + i);
        bus.cfg_start_adr = '0;
        bus.cfg_len       = '0;
        bus.cfg_div       = '0;
        bus.cfg_loop      = 1'b0;
        bus.start         = 1'b0;
        bus.stop          = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        run(16, 4, 0, 1'b0, 0, 0);
        run(16, 4, 3, 1'b0, 0, 0);
        run(2047, 3, 0, 1'b0, 0, 0);
        run(16, 2, 0, 1'b1, 8, 0);
        run(5, 0, 0, 1'b0, 0, 0);

        // start and stop together in idle: nothing happens
        @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check_outputs(1'b0, 1'b0, 1'b0);
            @(negedge clk);
        end

        run(16, 4, 3, 1'b0, 0, 6);
        run(100, 4095, 0, 1'b0, 0, 0);

        for (int r = 0; r < 12; r++) begin
            sa       = $urandom_range(0, NWORDS - 1);
            len      = $urandom_range(1, 10);
            div      = $urandom_range(0, 4);
            lp       = 1'($urandom_range(0, 1));
            last_cyc = 2 + RD_LAT + (len - 1) * (div + 1);
            if (lp)                       stop_cyc = $urandom_range(3, 40);
            else if ($urandom_range(0, 1) == 1) stop_cyc = $urandom_range(1, last_cyc);
            else                          stop_cyc = 0;
            restart_cyc = (stop_cyc == 0 || stop_cyc > 2) ? 2 : 0;
            run(sa, len, div, lp, stop_cyc, restart_cyc);
        end

        // asynchronous reset in the middle of a looping run
        @(negedge clk);
        bus.cfg_start_adr = 11'h123;
        bus.cfg_len       = 12'd6;
        bus.cfg_div       = 16'd0;
        bus.cfg_loop      = 1'b1;
        bus.start         = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        exp_data = '0;
        g_adr    = '0;
        g_lc     = 0;
        check_outputs(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_outputs(1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
